// File: rtl/uart_rx_framed.sv
// uart_rx_framed: parametrised UART receiver with majority voting, error flags and valid/ready output.
// Ports: clk, rst (async active-high); rx serial line (idle high, async);
//   valid/ready handshake; data received word (LSB first on line);
//   parity_err, frame_err, break_det, overrun status of the held word.
module uart_rx_framed #(
  parameter int pClkHz    = 0,
  parameter int pBaudRate = 0,
  parameter int pDataBits = 8,
  parameter int pParity   = 0,
  parameter int pStopBits = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 valid,
  input  logic                 ready,
  output logic [pDataBits-1:0] data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun
);
  localparam int T  = pClkHz / (pBaudRate > 0 ? pBaudRate : 1);
  localparam int H  = T / 2;
  localparam int CW = T >= 4 ? $clog2(T) : 2;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_BRK   = 3'd5;
  if (T < 4) begin : g_bad_baud
    $error("uart_rx_framed: pClkHz / pBaudRate must be at least 4");
  end
  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic                 s0_q, s0_d, s1_q, s1_d;
  logic [pDataBits-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d, pbit_q, pbit_d;
  logic                 valid_q, valid_d, pe_q, pe_d, fe_q, fe_d, bd_q, bd_d, ov_q, ov_d;
  logic [pDataBits-1:0] data_q, data_d;
  logic                 maj, at_h1, at_end, done, ferr_now, brk, take;
  assign rx_s     = sync_q[1];
  // samples at H-1 and H are held so the vote completes at H+1
  assign maj      = (s0_q & s1_q) | (rx_s & (s0_q | s1_q));
  assign at_h1    = cnt_q == CW'(H + 1);
  assign at_end   = cnt_q == CW'(T - 1);
  assign done     = state_q == S_STOP && bit_q == 4'(pStopBits - 1) && at_h1;
  assign ferr_now = ferr_q | ~maj;
  assign brk      = shift_q == '0 && !pbit_q && ferr_now;
  // a completing frame is accepted unless an unconsumed word is still held
  assign take     = done && (!valid_q || ready);
  assign s0_d     = cnt_q == CW'(H - 1) ? rx_s : s0_q;
  assign s1_d     = cnt_q == CW'(H) ? rx_s : s1_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = at_end ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    pbit_d  = pbit_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = S_START;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          pbit_d  = 1'b0;
        end
      end
      S_START: begin
        if (at_h1 && maj) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (at_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (at_h1) shift_d = {maj, shift_q[pDataBits-1:1]};
        if (at_end) begin
          bit_d = bit_q + 1'b1;
          if (bit_q == 4'(pDataBits - 1)) begin
            state_d = pParity != 0 ? S_PAR : S_STOP;
            bit_d   = '0;
          end
        end
      end
      S_PAR: begin
        if (at_h1) begin
          pbit_d = maj;
          // odd parity wants data^bit = 1, even wants 0
          perr_d = ^shift_q ^ maj ^ (pParity == 1);
        end
        if (at_end) begin
          state_d = S_STOP;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        if (at_h1) ferr_d = ferr_now;
        if (done) begin
          state_d = brk ? S_BRK : S_IDLE;
          cnt_d   = '0;
        end else if (at_end) bit_d = bit_q + 1'b1;
      end
      S_BRK: begin
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  assign valid_d = take || (valid_q && !ready);
  assign data_d  = take ? shift_q : data_q;
  assign pe_d    = take ? perr_q : pe_q;
  assign fe_d    = take ? ferr_now : fe_q;
  assign bd_d    = take ? brk : bd_q;
  assign ov_d    = take ? 1'b0 : (done && valid_q) ? 1'b1 : ov_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      pbit_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      bd_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      pbit_q  <= pbit_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      bd_q    <= bd_d;
      ov_q    <= ov_d;
    end
  end
  assign valid      = valid_q;
  assign data       = data_q;
  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign break_det  = bd_q;
  assign overrun    = ov_q;
endmodule

// File: tb/tb_uart_rx_framed.sv
// tb_uart_rx_framed: directed self-checking bench for uart_rx_framed (8N1, 8E1, 8O1 at T = 16).
module tb_uart_rx_framed;
  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int T      = 16;
  localparam int H      = 8;
  typedef struct {logic [7:0] d; logic pe, fe, bd, ov; int t;} rec_t;
  logic clk = 1'b0, rst = 1'b1, line = 1'b1, ready = 1'b1;
  int sel_r = 0, cyc = 0, fall = 0, ncmp = 0, nfail = 0, t;
  logic rx0, rx1, rx2;
  logic v0, v1, v2, pe0, pe1, pe2, fe0, fe1, fe2, bd0, bd1, bd2, ov0, ov1, ov2;
  logic [7:0] d0, d1, d2;
  rec_t q0[$], q1[$], q2[$];
  assign rx0 = sel_r == 0 ? line : 1'b1;
  assign rx1 = sel_r == 1 ? line : 1'b1;
  assign rx2 = sel_r == 2 ? line : 1'b1;
  uart_rx_framed #(.pClkHz(CLK_HZ), .pBaudRate(BAUD), .pDataBits(8), .pParity(0), .pStopBits(1)) u_n (
    .clk(clk), .rst(rst), .rx(rx0), .valid(v0), .ready(ready), .data(d0),
    .parity_err(pe0), .frame_err(fe0), .break_det(bd0), .overrun(ov0));
  uart_rx_framed #(.pClkHz(CLK_HZ), .pBaudRate(BAUD), .pDataBits(8), .pParity(2), .pStopBits(1)) u_e (
    .clk(clk), .rst(rst), .rx(rx1), .valid(v1), .ready(ready), .data(d1),
    .parity_err(pe1), .frame_err(fe1), .break_det(bd1), .overrun(ov1));
  uart_rx_framed #(.pClkHz(CLK_HZ), .pBaudRate(BAUD), .pDataBits(8), .pParity(1), .pStopBits(1)) u_o (
    .clk(clk), .rst(rst), .rx(rx2), .valid(v2), .ready(ready), .data(d2),
    .parity_err(pe2), .frame_err(fe2), .break_det(bd2), .overrun(ov2));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic rec_t mk(logic [7:0] d, logic pe, logic fe, logic bd, logic ov, int tt);
    rec_t r;
    r.d = d; r.pe = pe; r.fe = fe; r.bd = bd; r.ov = ov; r.t = tt;
    return r;
  endfunction
  // ready only changes just after a rising edge, so here it equals the value the next edge sees
  always @(negedge clk) begin
    if (v0 && ready) q0.push_back(mk(d0, pe0, fe0, bd0, ov0, cyc));
    if (v1 && ready) q1.push_back(mk(d1, pe1, fe1, bd1, ov1, cyc));
    if (v2 && ready) q2.push_back(mk(d2, pe2, fe2, bd2, ov2, cyc));
  end
  function automatic int qsize(int sel);
    return sel == 0 ? q0.size() : sel == 1 ? q1.size() : q2.size();
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic expect_count(input int sel, input string tag, input int n);
    chk(tag, qsize(sel), n);
  endtask
  task automatic expect_word(input int sel, input string tag, input logic [7:0] d,
                             input logic pe, input logic fe, input logic bd, input logic ov, output int tt);
    rec_t r;
    r = mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    if (sel == 0 && q0.size() > 0) r = q0.pop_front();
    else if (sel == 1 && q1.size() > 0) r = q1.pop_front();
    else if (sel == 2 && q2.size() > 0) r = q2.pop_front();
    chk({tag, " data"}, 32'(r.d), 32'(d));
    chk({tag, " parity_err"}, 32'(r.pe), 32'(pe));
    chk({tag, " frame_err"}, 32'(r.fe), 32'(fe));
    chk({tag, " break_det"}, 32'(r.bd), 32'(bd));
    chk({tag, " overrun"}, 32'(r.ov), 32'(ov));
    tt = r.t;
  endtask
  // called on a falling edge; one bit per T cycles, optional 1-cycle inversion mid data bit
  task automatic send(input int sel, input logic [7:0] d, input bit par_en, input logic pbit,
                      input logic stopv, input int gap, input bit glitch);
    sel_r = sel;
    line = 1'b0;
    fall = cyc;
    repeat (T) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      line = d[i];
      if (glitch) begin
        repeat (H) @(negedge clk);
        line = ~d[i];
        @(negedge clk);
        line = d[i];
        repeat (T - H - 1) @(negedge clk);
      end else repeat (T) @(negedge clk);
    end
    if (par_en) begin
      line = pbit;
      repeat (T) @(negedge clk);
    end
    line = stopv;
    repeat (T) @(negedge clk);
    line = 1'b1;
    repeat (gap * T) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("reset valid", 32'(v0), 0);
    chk("reset data", 32'(d0), 0);
    chk("reset parity_err", 32'(pe0), 0);
    chk("reset frame_err", 32'(fe0), 0);
    chk("reset break_det", 32'(bd0), 0);
    chk("reset overrun", 32'(ov0), 0);
    rst = 1'b0;
    repeat (2 * T) @(negedge clk);
    send(0, 8'hA5, 0, 1'b0, 1'b1, 2, 0);
    expect_count(0, "a5 count", 1);
    expect_word(0, "a5", 8'hA5, 0, 0, 0, 0, t);
    // the first rising edge after the pin falls is cycle 0
    chk("a5 latency", 32'(t - fall - 1), 156);
    send(0, 8'h00, 0, 1'b0, 1'b1, 0, 0);
    send(0, 8'hFF, 0, 1'b0, 1'b1, 2, 0);
    expect_count(0, "b2b count", 2);
    expect_word(0, "b2b 00", 8'h00, 0, 0, 0, 0, t);
    expect_word(0, "b2b ff", 8'hFF, 0, 0, 0, 0, t);
    send(1, 8'h03, 1, 1'b1, 1'b1, 2, 0);
    expect_count(1, "even bad count", 1);
    expect_word(1, "even bad", 8'h03, 1, 0, 0, 0, t);
    send(1, 8'h03, 1, 1'b0, 1'b1, 2, 0);
    expect_count(1, "even good count", 1);
    expect_word(1, "even good", 8'h03, 0, 0, 0, 0, t);
    send(2, 8'h03, 1, 1'b0, 1'b1, 2, 0);
    expect_count(2, "odd bad count", 1);
    expect_word(2, "odd bad", 8'h03, 1, 0, 0, 0, t);
    send(2, 8'h03, 1, 1'b1, 1'b1, 2, 0);
    expect_count(2, "odd good count", 1);
    expect_word(2, "odd good", 8'h03, 0, 0, 0, 0, t);
    send(0, 8'h5A, 0, 1'b0, 1'b0, 2, 0);
    expect_count(0, "stop0 count", 1);
    expect_word(0, "stop0", 8'h5A, 0, 1, 0, 0, t);
    send(0, 8'h11, 0, 1'b0, 1'b1, 2, 0);
    expect_count(0, "11 count", 1);
    expect_word(0, "11", 8'h11, 0, 0, 0, 0, t);
    sel_r = 0;
    line = 1'b0;
    repeat (5) @(negedge clk);
    line = 1'b1;
    repeat (3 * T) @(negedge clk);
    expect_count(0, "false start count", 0);
    send(0, 8'h3C, 0, 1'b0, 1'b1, 2, 1);
    expect_count(0, "glitch count", 1);
    expect_word(0, "glitch", 8'h3C, 0, 0, 0, 0, t);
    @(posedge clk); #1 ready = 1'b0;
    @(negedge clk);
    send(0, 8'h12, 0, 1'b0, 1'b1, 2, 0);
    send(0, 8'h34, 0, 1'b0, 1'b1, 2, 0);
    chk("ovr valid", 32'(v0), 1);
    chk("ovr data", 32'(d0), 32'h12);
    chk("ovr overrun", 32'(ov0), 1);
    expect_count(0, "ovr held count", 0);
    @(posedge clk); #1 ready = 1'b1;
    @(posedge clk); #1 ready = 1'b0;
    @(negedge clk);
    chk("ovr valid drop", 32'(v0), 0);
    expect_count(0, "ovr take count", 1);
    expect_word(0, "ovr take", 8'h12, 0, 0, 0, 1, t);
    @(posedge clk); #1 ready = 1'b1;
    @(negedge clk);
    send(0, 8'h56, 0, 1'b0, 1'b1, 2, 0);
    expect_count(0, "56 count", 1);
    expect_word(0, "56", 8'h56, 0, 0, 0, 0, t);
    sel_r = 0;
    line = 1'b0;
    repeat (20 * T) @(negedge clk);
    line = 1'b1;
    repeat (3 * T) @(negedge clk);
    expect_count(0, "break count", 1);
    expect_word(0, "break", 8'h00, 0, 1, 1, 0, t);
    send(0, 8'h77, 0, 1'b0, 1'b1, 2, 0);
    expect_count(0, "77 count", 1);
    expect_word(0, "77", 8'h77, 0, 0, 0, 0, t);
    line = 1'b0;
    repeat (T) @(negedge clk);
    line = 1'b1;
    repeat (T) @(negedge clk);
    line = 1'b0;
    repeat (T) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst valid", 32'(v0), 0);
    chk("midrst data", 32'(d0), 0);
    chk("midrst parity data", 32'(d1), 0);
    chk("midrst frame_err", 32'(fe0), 0);
    chk("midrst break_det", 32'(bd0), 0);
    chk("midrst overrun", 32'(ov0), 0);
    repeat (2) @(negedge clk);
    line = 1'b1;
    rst = 1'b0;
    repeat (12 * T) @(negedge clk);
    expect_count(0, "midrst count", 0);
    chk("midrst valid after", 32'(v0), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
